core_ctrl_fsm: RTL and testbench

Multi-cycle sequencer for the educational RV32 core (ADD/SUB/ADDI/LW/SW/BEQ/JAL subset).
- Drives instruction fetch, the decode/execute/memory/writeback steps, register-file and PC write strobes, and data-memory requests.
- Consumes the semantic control outputs of the instruction decoder.
- Sits between the decoder/datapath and the instruction/data memory req/ack interfaces.

---
 rtl/core_ctrl_fsm.sv | 181 ++++++++++++++++++
 tb/tb_core_ctrl_fsm.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/core_ctrl_fsm.sv
// core_ctrl_fsm: multi-cycle sequencer for the educational RV32 core
// (ADD/SUB/ADDI/LW/SW/BEQ/JAL subset).
// Optional feature macro: CORE_CTRL_INSTRET_EN adds the instret[31:0] retired-instruction counter.

package riscv_defs;
  typedef enum logic [1:0] {
    PC_PLUS_4 = 2'd0,
    PC_BRANCH = 2'd1,
    PC_JUMP   = 2'd2
  } pc_sel_t;
endpackage

module core_ctrl_fsm #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req,
  input  logic                imem_ack,
  output logic                ir_we,
  input  logic                dec_valid,
  input  logic                dec_writes_rd,
  input  logic                dec_is_load,
  input  logic                dec_is_store,
  input  logic                dec_is_branch,
  input  logic                dec_is_jump,
  input  logic                alu_zero,
  output logic                dmem_req,
  output logic                dmem_we,
  input  logic                dmem_ack,
  output logic                rf_we,
  output logic                pc_we,
  output riscv_defs::pc_sel_t pc_sel,
  output logic                halted,
  output logic                illegal,
  output logic                bus_err,
  output logic [2:0]          state_dbg
`ifdef CORE_CTRL_INSTRET_EN
  ,
  output logic [31:0]         instret
`endif
);
  import riscv_defs::*;

  // A zero timeout still needs a 1-bit counter to keep the declarations legal.
  localparam int unsigned WCNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WCNT_W-1:0] WCNT_LIMIT = WCNT_W'(MEM_TIMEOUT);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [WCNT_W-1:0] wait_q, wait_d;
  logic              illegal_q, illegal_d;
  logic              bus_err_q, bus_err_d;
  logic              waiting, acked, timed_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH;
      wait_q    <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;
    waiting   = 1'b0;
    acked     = 1'b0;
    case (state_q)
      FETCH:   begin waiting = 1'b1; acked = imem_ack; end
      MEM:     begin waiting = 1'b1; acked = dmem_ack; end
      default: ;
    endcase
    // An ack on the limit cycle completes the access instead of timing out.
    timed_out = (MEM_TIMEOUT != 0) && waiting && !acked && (wait_q == WCNT_LIMIT);

    case (state_q)
      FETCH:  if (imem_ack) state_d = DECODE;
      DECODE: begin
        if (!dec_valid) begin
          state_d   = HALT;
          illegal_d = 1'b1;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (dec_is_load || dec_is_store)       state_d = MEM;
        else if (dec_is_branch || dec_is_jump) state_d = FETCH;
        else                                   state_d = WB;
      end
      MEM:     if (dmem_ack) state_d = dec_is_store ? FETCH : WB;
      WB:      state_d = FETCH;
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase

    if (timed_out) begin
      state_d   = HALT;
      bus_err_d = 1'b1;
    end

    wait_d = (waiting && !acked && !timed_out && (MEM_TIMEOUT != 0)) ? wait_q + 1'b1 : '0;
  end

  always_comb begin
    imem_req = 1'b0;
    ir_we    = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = PC_PLUS_4;
    if (!rst) begin
      case (state_q)
        FETCH: begin
          imem_req = 1'b1;
          ir_we    = imem_ack;
        end
        EXEC: begin
          if (!(dec_is_load || dec_is_store)) begin
            if (dec_is_branch) begin
              pc_we  = 1'b1;
              pc_sel = alu_zero ? PC_BRANCH : PC_PLUS_4;
            end else if (dec_is_jump) begin
              pc_we  = 1'b1;
              pc_sel = PC_JUMP;
              rf_we  = dec_writes_rd;
            end
          end
        end
        MEM: begin
          dmem_req = 1'b1;
          dmem_we  = dec_is_store;
          pc_we    = dmem_ack && dec_is_store;
        end
        WB: begin
          rf_we = dec_writes_rd;
          pc_we = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign halted    = (state_q == HALT);
  assign illegal   = illegal_q;
  assign bus_err   = bus_err_q;
  assign state_dbg = state_q;

`ifdef CORE_CTRL_INSTRET_EN
  logic [31:0] instret_q, instret_d;

  always_comb begin
    instret_d = instret_q + {31'd0, pc_we};
  end

  always_ff @(posedge clk) begin
    if (rst) instret_q <= '0;
    else     instret_q <= instret_d;
  end

  assign instret = instret_q;
`endif

endmodule

// File: tb/tb_core_ctrl_fsm.sv
// Randomised bench for core_ctrl_fsm: instructions are expanded into an
// expected per-cycle trace from their class and ack delays, then replayed.

module tb_core_ctrl_fsm;
  import riscv_defs::*;

  localparam int unsigned TO = 15;
  localparam int unsigned K_ALU = 0, K_LW = 1, K_SW = 2, K_BEQ = 3, K_JAL = 4, K_ILL = 5;

  logic clk = 1'b0;
  logic rst, imem_ack, dmem_ack, alu_zero;
  logic dec_valid, dec_writes_rd, dec_is_load, dec_is_store, dec_is_branch, dec_is_jump;
  logic imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, halted, illegal, bus_err;
  logic [2:0] state_dbg;
  pc_sel_t pc_sel;
`ifdef CORE_CTRL_INSTRET_EN
  logic [31:0] instret;
  logic [31:0] exp_instret = '0;
`endif

  always #5 clk = ~clk;

  core_ctrl_fsm #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_ack(imem_ack), .ir_we(ir_we),
    .dec_valid(dec_valid), .dec_writes_rd(dec_writes_rd), .dec_is_load(dec_is_load),
    .dec_is_store(dec_is_store), .dec_is_branch(dec_is_branch), .dec_is_jump(dec_is_jump),
    .alu_zero(alu_zero),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .rf_we(rf_we), .pc_we(pc_we), .pc_sel(pc_sel),
    .halted(halted), .illegal(illegal), .bus_err(bus_err), .state_dbg(state_dbg)
`ifdef CORE_CTRL_INSTRET_EN
    , .instret(instret)
`endif
  );

  typedef struct {
    string       tag;
    bit          rst, iack, dack, z;
    bit          dv, wr, ld, st, br, jp;
    int unsigned st_e;
    bit          ireq, irwe, dreq, dwe, rfwe, pcwe;
    pc_sel_t     sel;
    bit          hlt, ill, berr;
  } cyc_t;

  cyc_t        q[$];
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  bit          cur_dv, cur_wr, cur_ld, cur_st, cur_br, cur_jp;
  bit          f_hlt, f_ill, f_berr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit rb();
    return bit'($urandom & 1);
  endfunction

  // One cycle of the expected trace; acks and unconsumed inputs are noise.
  function automatic cyc_t cyc(input int unsigned s, input string tag);
    cyc_t c;
    c.tag  = tag;
    c.st_e = s;
    c.sel  = PC_PLUS_4;
    c.hlt  = f_hlt; c.ill = f_ill; c.berr = f_berr;
    c.iack = rb(); c.dack = rb(); c.z = rb();
    if (s == 0) begin
      c.iack = 1'b0;
      c.dv = rb(); c.wr = rb(); c.ld = rb(); c.st = rb(); c.br = rb(); c.jp = rb();
    end else begin
      c.dv = cur_dv; c.wr = cur_wr; c.ld = cur_ld; c.st = cur_st; c.br = cur_br; c.jp = cur_jp;
    end
    if (s == 3) c.dack = 1'b0;
    return c;
  endfunction

  task automatic gen_reset(input int unsigned n);
    cyc_t c;
    f_hlt = 1'b0; f_ill = 1'b0; f_berr = 1'b0;
    for (int unsigned i = 0; i < n; i++) begin
      c = cyc(0, "reset");
      c.rst  = 1'b1;
      c.iack = rb();
      q.push_back(c);
    end
  endtask

  task automatic gen_halt(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) q.push_back(cyc(5, "halt"));
  endtask

  task automatic gen_instr(input int unsigned kind, input int unsigned fd, input int unsigned md,
                           input bit wr, input bit z, input bit x1, input bit x2,
                           input int unsigned mem_rst);
    cyc_t c;
    cur_dv = (kind != K_ILL); cur_wr = wr;
    cur_ld = (kind == K_LW);  cur_st = (kind == K_SW);
    cur_br = (kind == K_BEQ); cur_jp = (kind == K_JAL);
    if (cur_ld || cur_st) begin cur_br = x1; cur_jp = x2; end
    else if (cur_br) cur_jp = x1;
    else if (kind == K_ILL) begin cur_ld = x1; cur_br = x2; end

    for (int unsigned i = 0; i < fd && i <= TO; i++) begin
      c = cyc(0, "fetch_wait"); c.ireq = 1'b1; q.push_back(c);
    end
    if (fd > TO) begin
      f_hlt = 1'b1; f_berr = 1'b1; gen_halt(12); return;
    end
    c = cyc(0, "fetch_ack"); c.ireq = 1'b1; c.irwe = 1'b1; c.iack = 1'b1; q.push_back(c);
    q.push_back(cyc(1, "decode"));
    if (kind == K_ILL) begin
      f_hlt = 1'b1; f_ill = 1'b1; gen_halt(20); return;
    end

    c = cyc(2, "exec"); c.z = z;
    if (cur_ld || cur_st) ;
    else if (cur_br) begin c.pcwe = 1'b1; c.sel = z ? PC_BRANCH : PC_PLUS_4; end
    else if (cur_jp) begin c.pcwe = 1'b1; c.sel = PC_JUMP; c.rfwe = wr; end
    q.push_back(c);
    if (!(cur_ld || cur_st) && (cur_br || cur_jp)) return;

    if (cur_ld || cur_st) begin
      for (int unsigned i = 0; i < md && i <= TO; i++) begin
        if (mem_rst != 0 && i + 1 == mem_rst) begin gen_reset(2); return; end
        c = cyc(3, "mem_wait"); c.dreq = 1'b1; c.dwe = cur_st; q.push_back(c);
      end
      if (md > TO) begin
        f_hlt = 1'b1; f_berr = 1'b1; gen_halt(12); return;
      end
      c = cyc(3, "mem_ack"); c.dreq = 1'b1; c.dwe = cur_st; c.dack = 1'b1;
      c.pcwe = cur_st;
      q.push_back(c);
      if (cur_st) return;
    end
    c = cyc(4, "wb"); c.rfwe = wr; c.pcwe = 1'b1; q.push_back(c);
  endtask

  task automatic run_queue();
    cyc_t        c;
    logic [31:0] obs, exp;
    int unsigned idx = 0;
    while (q.size() > 0) begin
      c = q.pop_front();
      @(negedge clk);
      rst = c.rst; imem_ack = c.iack; dmem_ack = c.dack; alu_zero = c.z;
      dec_valid = c.dv; dec_writes_rd = c.wr; dec_is_load = c.ld;
      dec_is_store = c.st; dec_is_branch = c.br; dec_is_jump = c.jp;
      #1;
      obs = {18'd0, (rst ? 3'd0 : state_dbg), imem_req, ir_we, dmem_req, dmem_req & dmem_we,
             rf_we, pc_we, (pc_we ? 2'(pc_sel) : 2'd0),
             (rst ? 1'b0 : halted), (rst ? 1'b0 : illegal), (rst ? 1'b0 : bus_err)};
      exp = {18'd0, (c.rst ? 3'd0 : 3'(c.st_e)), c.ireq, c.irwe, c.dreq, c.dreq & c.dwe,
             c.rfwe, c.pcwe, (c.pcwe ? 2'(c.sel) : 2'd0),
             (c.rst ? 1'b0 : c.hlt), (c.rst ? 1'b0 : c.ill), (c.rst ? 1'b0 : c.berr)};
      check_eq($sformatf("%s@%0d", c.tag, idx), obs, exp);
`ifdef CORE_CTRL_INSTRET_EN
      if (!c.rst) check_eq($sformatf("instret@%0d", idx), instret, exp_instret);
      if (c.rst) exp_instret = '0;
      else if (c.pcwe) exp_instret = exp_instret + 1;
`endif
      idx++;
    end
  endtask

  initial begin
    rst = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0; alu_zero = 1'b0;
    dec_valid = 1'b0; dec_writes_rd = 1'b0; dec_is_load = 1'b0;
    dec_is_store = 1'b0; dec_is_branch = 1'b0; dec_is_jump = 1'b0;

    gen_reset(3);
    // directed instruction classes
    gen_instr(K_ALU, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    gen_instr(K_LW,  0, 2, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    gen_instr(K_SW,  0, 2, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    gen_instr(K_BEQ, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    gen_instr(K_BEQ, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    gen_instr(K_JAL, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    // random mix, priority overlaps and ack delays up to the limit
    for (int i = 0; i < 60; i++) begin
      int unsigned k, fd, md;
      k  = $urandom_range(0, 4);
      fd = ($urandom_range(0, 3) == 0) ? $urandom_range(0, TO) : $urandom_range(0, 2);
      md = ($urandom_range(0, 3) == 0) ? $urandom_range(0, TO) : $urandom_range(0, 2);
      gen_instr(k, fd, md, rb(), rb(), rb(), rb(), 0);
    end
    // illegal instruction halts; reset recovers
    gen_instr(K_ILL, 0, 0, rb(), 1'b0, rb(), rb(), 0);
    gen_reset(1);
    gen_instr(K_ALU, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    // fetch timeout, then ack exactly on the limit cycle
    gen_instr(K_ALU, TO + 1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    gen_reset(1);
    gen_instr(K_ALU, TO, 0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    // data timeout, then data ack on the limit cycle
    gen_instr(K_LW, 0, TO + 1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    gen_reset(1);
    gen_instr(K_SW, 0, TO, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    // reset in the middle of a data access
    gen_instr(K_LW, 0, 10, 1'b1, 1'b0, 1'b0, 1'b0, 3);
    gen_instr(K_ALU, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    gen_instr(K_LW, 1, 1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    gen_instr(K_SW, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    gen_instr(K_BEQ, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    gen_instr(K_JAL, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 0);

    run_queue();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
